mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
- Upstream stage of the main memory block. Arbitrates NUM_PORTS requesters (vector load/store units) onto the memory's single request interface.
- Keeps at most one memory transaction outstanding and routes each response back to the port that issued it, restoring that port's own request id.
- Times out lost responses and flags id mismatches.

Parameters:
- NUM_PORTS, 4, number of requester ports (2..16).
- TIMEOUT, 255, cycles allowed in WAIT_RSP before abort (1..65535).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- p_valid  input  NUM_PORTS  per-port request valid.
- p_ready  output  NUM_PORTS  per-port request accept; one-hot or zero.
- p_write  input  NUM_PORTS  per-port op: 1 = write, 0 = read.
- p_id  input  4*NUM_PORTS  per-port requester id; port i uses bits [4i+3:4i].
- p_addr  input  32*NUM_PORTS  per-port line address.
- p_byte_en  input  8*NUM_PORTS  per-port byte enables (writes only).
- p_wdata  input  64*NUM_PORTS  per-port write data.
- p_rsp_valid  output  NUM_PORTS  one-cycle response strobe to the owning port.
- p_rsp_write  output  1  response is a write acknowledge.
- p_rsp_id  output  4  original requester id.
- p_rsp_rdata  output  64  read data (0 for writes and errors).
- p_rsp_err  output  1  response produced by timeout.
- req_write, req_read  output  1 each  memory request strobes.
- req_id  output  4  issuing port index, zero-extended.
- req_addr  output  32  memory address.
- req_byte_en  output  8  memory byte enables.
- req_write_data  output  64  memory write data.
- rsp_write, rsp_read  input  1 each  memory response strobes.
- rsp_id  input  4  memory response id.
- rsp_read_data  input  64  memory read data.
- mem_ready  input  1  memory can latch a request at this edge.
- id_err  output  1  sticky: rsp_id differed from the stored port index.
- timeout_err  output  1  sticky: a timeout occurred.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE; rr_ptr = NUM_PORTS-1, so port 0 has first priority.
  - All outputs 0, including the sticky flags and the timeout counter.
  - Any in-flight transaction is dropped with no response; a late memory response after reset release is ignored because the block is in IDLE.
- FSM: IDLE -> ISSUE -> WAIT_RSP -> IDLE.
- IDLE:
  - If any p_valid is set, grant the first valid port scanning from rr_ptr+1 with wrap-around.
  - p_ready[g] is asserted combinationally in the same cycle.
  - The request fields are captured into registers and the port index and requester id are stored.
  - rr_ptr <= g; next state ISSUE.
  - p_ready is 0 in every other state.
- ISSUE:
  - Drive req_write = op, req_read = !op. The two are never both 1.
  - Drive req_id = g and the captured addr/byte_en/wdata. For reads, req_byte_en = 0 and req_write_data = 0.
  - Hold all of these until an edge where mem_ready = 1; that edge is the memory's latch point.
  - Then go to WAIT_RSP and deassert req_write/req_read, req_id and the data fields to 0.
  - mem_ready low: stay in ISSUE indefinitely (no timeout here).
- WAIT_RSP:
  - The counter increments every cycle.
  - On rsp_write or rsp_read, register the response for the next cycle:
    - p_rsp_valid[g] = 1 for one cycle.
    - p_rsp_write = rsp_write, p_rsp_id = stored id.
    - p_rsp_rdata = rsp_read_data for reads, 0 for writes.
    - p_rsp_err = 0.
  - If rsp_id != g, set id_err; the response still routes to g.
  - Next state IDLE; clear the counter.
  - Response latency to the port is 1 cycle after the memory strobe.
- Timeout:
  - If the counter reaches TIMEOUT with no response, go to IDLE and set timeout_err.
  - Emit p_rsp_valid[g] with p_rsp_err = 1, p_rsp_rdata = 0 and p_rsp_id = stored id.
  - A response arriving in the same cycle as the timeout wins: it is routed normally, with no error.
- Memory response strobes outside WAIT_RSP are ignored.
- All p_rsp_* outputs return to 0 the cycle after the strobe.
- A new grant in IDLE may coincide with the p_rsp_valid cycle of the previous transaction.
- p_* inputs of non-granted ports are don't-care. A requester must hold its fields stable while p_valid=1 and p_ready=0.

Test Plan:
- Reset release, port 1 read addr 0x10 with id 5, memory returns 0xDEAD_BEEF:
  - p_ready[1] in the request cycle; req_read=1, req_id=1 until mem_ready.
  - p_rsp_valid[1]=1, p_rsp_id=5, p_rsp_rdata=0xDEADBEEF one cycle after rsp_read.
- Port 0 write addr 0x20, byte_en 0x0F, data 0x1122334455667788, then a port 0 read of 0x20:
  - The write ack has p_rsp_write=1.
  - The read returns 0x0000000055667788 (memory pre-cleared).
- All four ports valid continuously:
  - Grant order 0,1,2,3,0.
  - Exactly one outstanding transaction; p_ready never multi-hot.
- mem_ready held 0 for 10 cycles in ISSUE:
  - req_read stays asserted with stable fields; no p_ready for other ports.
  - Issue completes on the first mem_ready=1 edge.
- TIMEOUT=8, memory never responds:
  - p_rsp_valid[g] with p_rsp_err=1 exactly 8 cycles after entering WAIT_RSP; timeout_err stays 1.
  - A separate run with the response in the 8th cycle: normal response, no error.
- Reset asserted during WAIT_RSP, then memory response after release:
  - All outputs 0 immediately on assertion.
  - The late response is ignored; the next request is granted normally.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter that funnels NUM_PORTS requesters onto a single memory
// request interface. One transaction at a time; responses are routed back to the issuing port.
module mem_req_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_PORTS-1:0]      p_valid,
  output logic [NUM_PORTS-1:0]      p_ready,
  input  logic [NUM_PORTS-1:0]      p_write,
  input  logic [4*NUM_PORTS-1:0]    p_id,
  input  logic [32*NUM_PORTS-1:0]   p_addr,
  input  logic [8*NUM_PORTS-1:0]    p_byte_en,
  input  logic [64*NUM_PORTS-1:0]   p_wdata,
  output logic [NUM_PORTS-1:0]      p_rsp_valid,
  output logic                      p_rsp_write,
  output logic [3:0]                p_rsp_id,
  output logic [63:0]               p_rsp_rdata,
  output logic                      p_rsp_err,
  output logic                      req_write,
  output logic                      req_read,
  output logic [3:0]                req_id,
  output logic [31:0]               req_addr,
  output logic [7:0]                req_byte_en,
  output logic [63:0]               req_write_data,
  input  logic                      rsp_write,
  input  logic                      rsp_read,
  input  logic [3:0]                rsp_id,
  input  logic [63:0]               rsp_read_data,
  input  logic                      mem_ready,
  output logic                      id_err,
  output logic                      timeout_err
);

  localparam int unsigned IDW = 4;
  localparam int unsigned AW  = 32;
  localparam int unsigned BEW = 8;
  localparam int unsigned DW  = 64;
  localparam int unsigned PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CW  = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_d;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   grant_idx;
  logic            grant_any;
  logic            grant_fire;
  logic [PW-1:0]   own_port;
  logic [IDW-1:0]  own_id;
  logic [CW-1:0]   wait_cnt;
  logic            issue_done;
  logic            rsp_hit;
  logic            timeout_hit;

  // Port index base+off, wrapped into 0..NUM_PORTS-1
  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return PW'(s);
  endfunction

  // First valid port after the last winner
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      if (!grant_any && p_valid[wrap_idx(rr_ptr, k)]) begin
        grant_any = 1'b1;
        grant_idx = wrap_idx(rr_ptr, k);
      end
    end
  end

  assign grant_fire = (state == IDLE) && grant_any;

  // Accept is combinational so the requester sees it in its request cycle
  always_comb begin
    p_ready = '0;
    if (reset && grant_fire) p_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // A response in the final wait cycle takes priority over the timeout
  always_comb begin
    state_d     = state;
    issue_done  = 1'b0;
    rsp_hit     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) state_d = ISSUE;
      end
      ISSUE: begin
        if (mem_ready) begin
          issue_done = 1'b1;
          state_d    = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (rsp_write || rsp_read) begin
          rsp_hit = 1'b1;
          state_d = IDLE;
        end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture; fields stay on the bus for the whole ISSUE state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_write      <= 1'b0;
      req_read       <= 1'b0;
      req_id         <= '0;
      req_addr       <= '0;
      req_byte_en    <= '0;
      req_write_data <= '0;
      own_port       <= '0;
      own_id         <= '0;
      rr_ptr         <= PW'(NUM_PORTS - 1);
    end else if (grant_fire) begin
      req_write      <= p_write[grant_idx];
      req_read       <= !p_write[grant_idx];
      req_id         <= IDW'(grant_idx);
      req_addr       <= p_addr[AW*32'(grant_idx) +: AW];
      req_byte_en    <= p_write[grant_idx] ? p_byte_en[BEW*32'(grant_idx) +: BEW] : '0;
      req_write_data <= p_write[grant_idx] ? p_wdata[DW*32'(grant_idx) +: DW] : '0;
      own_port       <= grant_idx;
      own_id         <= p_id[IDW*32'(grant_idx) +: IDW];
      rr_ptr         <= grant_idx;
    end else if (issue_done) begin
      req_write      <= 1'b0;
      req_read       <= 1'b0;
      req_id         <= '0;
      req_addr       <= '0;
      req_byte_en    <= '0;
      req_write_data <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                        wait_cnt <= '0;
    else if (state == WAIT_RSP && state_d == WAIT_RSP) wait_cnt <= wait_cnt + CW'(1);
    else                                               wait_cnt <= '0;
  end

  // One-cycle response strobe back to the owning port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_rsp_valid <= '0;
      p_rsp_write <= 1'b0;
      p_rsp_id    <= '0;
      p_rsp_rdata <= '0;
      p_rsp_err   <= 1'b0;
      id_err      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      p_rsp_valid <= '0;
      p_rsp_write <= 1'b0;
      p_rsp_id    <= '0;
      p_rsp_rdata <= '0;
      p_rsp_err   <= 1'b0;
      if (rsp_hit) begin
        p_rsp_valid[own_port] <= 1'b1;
        p_rsp_write           <= rsp_write;
        p_rsp_id              <= own_id;
        p_rsp_rdata           <= rsp_write ? '0 : rsp_read_data;
        if (rsp_id != IDW'(own_port)) id_err <= 1'b1;
      end else if (timeout_hit) begin
        p_rsp_valid[own_port] <= 1'b1;
        p_rsp_id              <= own_id;
        p_rsp_err             <= 1'b1;
        timeout_err           <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed vector table, randomized transactions against a
// memory/reference model, round-robin fairness and reset-abort sequences.
module tb_mem_req_arbiter;

  localparam int NP = 4;
  localparam int TO = 8;

  logic              clk;
  logic              reset;
  logic [NP-1:0]     p_valid;
  logic [NP-1:0]     p_ready;
  logic [NP-1:0]     p_write;
  logic [4*NP-1:0]   p_id;
  logic [32*NP-1:0]  p_addr;
  logic [8*NP-1:0]   p_byte_en;
  logic [64*NP-1:0]  p_wdata;
  logic [NP-1:0]     p_rsp_valid;
  logic              p_rsp_write;
  logic [3:0]        p_rsp_id;
  logic [63:0]       p_rsp_rdata;
  logic              p_rsp_err;
  logic              req_write;
  logic              req_read;
  logic [3:0]        req_id;
  logic [31:0]       req_addr;
  logic [7:0]        req_byte_en;
  logic [63:0]       req_write_data;
  logic              rsp_write;
  logic              rsp_read;
  logic [3:0]        rsp_id;
  logic [63:0]       rsp_read_data;
  logic              mem_ready;
  logic              id_err;
  logic              timeout_err;

  mem_req_arbiter #(.NUM_PORTS(NP), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .p_valid(p_valid), .p_ready(p_ready), .p_write(p_write), .p_id(p_id),
    .p_addr(p_addr), .p_byte_en(p_byte_en), .p_wdata(p_wdata),
    .p_rsp_valid(p_rsp_valid), .p_rsp_write(p_rsp_write), .p_rsp_id(p_rsp_id),
    .p_rsp_rdata(p_rsp_rdata), .p_rsp_err(p_rsp_err),
    .req_write(req_write), .req_read(req_read), .req_id(req_id), .req_addr(req_addr),
    .req_byte_en(req_byte_en), .req_write_data(req_write_data),
    .rsp_write(rsp_write), .rsp_read(rsp_read), .rsp_id(rsp_id),
    .rsp_read_data(rsp_read_data), .mem_ready(mem_ready),
    .id_err(id_err), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic exp_ide = 1'b0;
  logic exp_to  = 1'b0;

  logic [63:0] dev_mem [logic [31:0]];
  logic [63:0] ref_mem [logic [31:0]];

  typedef struct {
    int          port;
    logic        wr;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  be;
    logic [63:0] data;
    int          hold;
    int          rsp_cyc;
    logic        corrupt;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [7:0] be,
                                        input logic [63:0] d);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [63:0] dev_rd(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : 64'h0;
  endfunction

  function automatic logic [63:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 64'h0;
  endfunction

  // Random junk on every port's fields; only the granted port's slice matters
  task automatic junk();
    p_write   = NP'($urandom);
    p_id      = (4*NP)'($urandom);
    p_byte_en = (8*NP)'($urandom);
    for (int i = 0; i < NP; i++) p_addr[32*i +: 32] = $urandom;
    for (int i = 0; i < 2*NP; i++) p_wdata[32*i +: 32] = $urandom;
  endtask

  // One full transaction; rsp_cyc = wait cycle carrying the response, 0 = never
  task automatic do_txn(input int p, input logic w, input logic [3:0] id, input logic [31:0] a,
                        input logic [7:0] be, input logic [63:0] d, input int hold,
                        input int rsp_cyc, input logic corrupt, input logic [63:0] exp_rdata);
    logic        exp_err;
    logic        dev_w;
    logic [63:0] dev_data;
    logic [3:0]  dev_id;
    int          last;
    exp_err = (rsp_cyc == 0);
    @(negedge clk);
    rsp_write = 1'b0; rsp_read = 1'b0; mem_ready = 1'b0;
    junk();
    p_valid = '0; p_valid[p] = 1'b1;
    p_write[p] = w; p_id[4*p +: 4] = id; p_addr[32*p +: 32] = a;
    p_byte_en[8*p +: 8] = be; p_wdata[64*p +: 64] = d;
    #1;
    chk("rsp_idle", 64'(p_rsp_valid), 64'h0);
    chk("grant", 64'(p_ready), 64'(1) << p);
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      junk();
      p_valid   = (h < hold) ? '1 : '0;
      mem_ready = (h == hold);
      #1;
      chk("issue_no_ready", 64'(p_ready), 64'h0);
      chk("req_write", 64'(req_write), 64'(w));
      chk("req_read", 64'(req_read), 64'(!w));
      chk("req_id", 64'(req_id), 64'(p));
      chk("req_addr", 64'(req_addr), 64'(a));
      chk("req_byte_en", 64'(req_byte_en), w ? 64'(be) : 64'h0);
      chk("req_wdata", req_write_data, w ? d : 64'h0);
    end
    // Memory device latches what the arbiter presents
    dev_w    = req_write;
    dev_data = 64'h0;
    if (req_write) dev_mem[req_addr] = merge(dev_rd(req_addr), req_byte_en, req_write_data);
    else           dev_data = dev_rd(req_addr);
    dev_id = req_id ^ (corrupt ? 4'h1 : 4'h0);
    last = (rsp_cyc == 0) ? TO : rsp_cyc;
    for (int wc = 1; wc <= last; wc++) begin
      @(negedge clk);
      mem_ready = 1'b0; p_valid = '0;
      rsp_write = 1'b0; rsp_read = 1'b0;
      rsp_id = 4'($urandom); rsp_read_data = {$urandom, $urandom};
      if (wc == rsp_cyc) begin
        rsp_write = dev_w; rsp_read = !dev_w; rsp_id = dev_id;
        if (!dev_w) rsp_read_data = dev_data;
      end
      #1;
      chk("wait_quiet", 64'(p_rsp_valid), 64'h0);
      chk("req_off", 64'({req_write, req_read, req_id, req_byte_en}), 64'h0);
    end
    @(negedge clk);
    rsp_write = 1'b0; rsp_read = 1'b0;
    #1;
    if (exp_err) exp_to = 1'b1;
    else if (corrupt) exp_ide = 1'b1;
    chk("rsp_valid", 64'(p_rsp_valid), 64'(1) << p);
    chk("rsp_write", 64'(p_rsp_write), exp_err ? 64'h0 : 64'(w));
    chk("rsp_id", 64'(p_rsp_id), 64'(id));
    chk("rsp_rdata", p_rsp_rdata, exp_rdata);
    chk("rsp_err", 64'(p_rsp_err), 64'(exp_err));
    chk("id_err", 64'(id_err), 64'(exp_ide));
    chk("timeout_err", 64'(timeout_err), 64'(exp_to));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int          grants [$];
    int          outst;
    int          gi;
    logic        pend_r;
    logic [3:0]  pend_id;
    int          p, hold, rc;
    logic        w, corrupt;
    logic [3:0]  id;
    logic [31:0] a;
    logic [7:0]  be;
    logic [63:0] d, er;

    vecs[0] = '{1, 1'b0, 4'h5, 32'h10, 8'h00, 64'h0, 2, 1, 1'b0, 64'h0000_0000_DEAD_BEEF};
    vecs[1] = '{0, 1'b1, 4'h3, 32'h20, 8'h0F, 64'h1122_3344_5566_7788, 0, 2, 1'b0, 64'h0};
    vecs[2] = '{0, 1'b0, 4'h3, 32'h20, 8'h00, 64'h0, 0, 1, 1'b0, 64'h0000_0000_5566_7788};
    vecs[3] = '{2, 1'b1, 4'hA, 32'h20, 8'hF0, 64'hAABB_CCDD_9999_9999, 0, 3, 1'b0, 64'h0};
    vecs[4] = '{3, 1'b0, 4'hF, 32'h20, 8'h00, 64'h0, 10, 1, 1'b0, 64'hAABB_CCDD_5566_7788};
    vecs[5] = '{2, 1'b0, 4'h7, 32'h10, 8'h00, 64'h0, 0, 0, 1'b0, 64'h0};
    vecs[6] = '{1, 1'b0, 4'h9, 32'h20, 8'h00, 64'h0, 1, 8, 1'b0, 64'hAABB_CCDD_5566_7788};
    vecs[7] = '{3, 1'b1, 4'h2, 32'h30, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, 4, 1'b1, 64'h0};
    vecs[8] = '{0, 1'b0, 4'h1, 32'h30, 8'h00, 64'h0, 0, 5, 1'b0, 64'h0123_4567_89AB_CDEF};

    dev_mem[32'h10] = 64'h0000_0000_DEAD_BEEF;
    ref_mem[32'h10] = 64'h0000_0000_DEAD_BEEF;

    // Reset state, with every port requesting
    reset = 1'b0; mem_ready = 1'b0; rsp_write = 1'b0; rsp_read = 1'b0;
    rsp_id = '0; rsp_read_data = '0;
    junk(); p_valid = '1;
    #2;
    chk("rst_p_ready", 64'(p_ready), 64'h0);
    chk("rst_req", 64'({req_write, req_read, req_id, req_byte_en}), 64'h0);
    chk("rst_req_addr", 64'(req_addr), 64'h0);
    chk("rst_rsp", 64'({p_rsp_valid, p_rsp_write, p_rsp_id, p_rsp_err}), 64'h0);
    chk("rst_flags", 64'({id_err, timeout_err}), 64'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1; p_valid = '0;

    foreach (vecs[i]) begin
      if (vecs[i].wr) ref_mem[vecs[i].addr] = merge(ref_rd(vecs[i].addr), vecs[i].be, vecs[i].data);
      do_txn(vecs[i].port, vecs[i].wr, vecs[i].id, vecs[i].addr, vecs[i].be, vecs[i].data,
             vecs[i].hold, vecs[i].rsp_cyc, vecs[i].corrupt, vecs[i].exp_rdata);
    end

    for (int t = 0; t < 60; t++) begin
      p       = $urandom_range(0, NP - 1);
      w       = 1'($urandom_range(0, 1));
      id      = 4'($urandom);
      a       = 32'(16 * $urandom_range(1, 4));
      be      = 8'($urandom);
      d       = {$urandom, $urandom};
      hold    = $urandom_range(0, 3);
      rc      = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO);
      corrupt = ($urandom_range(0, 9) == 0);
      er      = (rc == 0 || w) ? 64'h0 : ref_rd(a);
      if (w) ref_mem[a] = merge(ref_rd(a), be, d);
      do_txn(p, w, id, a, be, d, hold, rc, corrupt, er);
    end

    // Reset during WAIT_RSP, then a stale response after release
    @(negedge clk);
    junk(); p_valid = '0; p_valid[2] = 1'b1; p_write[2] = 1'b0; p_addr[64 +: 32] = 32'h10;
    @(negedge clk); p_valid = '0; mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0; p_valid = '1;
    #1;
    chk("abort_p_ready", 64'(p_ready), 64'h0);
    chk("abort_req", 64'({req_write, req_read, req_id}), 64'h0);
    chk("abort_rsp", 64'({p_rsp_valid, p_rsp_err}), 64'h0);
    chk("abort_flags", 64'({id_err, timeout_err}), 64'h0);
    exp_ide = 1'b0; exp_to = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1; p_valid = '0;
    @(negedge clk);
    rsp_read = 1'b1; rsp_id = 4'h2; rsp_read_data = 64'hBAD;
    @(negedge clk);
    rsp_read = 1'b0;
    #1;
    chk("late_rsp_ignored", 64'(p_rsp_valid), 64'h0);
    chk("late_rsp_id_err", 64'(id_err), 64'h0);
    p_valid = '1;
    #1;
    chk("post_rst_priority", 64'(p_ready), 64'h1);
    #1;
    p_valid = '0;

    // All ports requesting: expect 0,1,2,3,0,... with one transaction in flight
    outst = 0; pend_r = 1'b0; pend_id = '0; gi = -1;
    p_write = '0; p_id = 16'h4321;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      rsp_read = pend_r; rsp_write = 1'b0; rsp_id = pend_id; rsp_read_data = 64'(c);
      pend_r = 1'b0;
      p_valid = (c < 40) ? '1 : '0;
      mem_ready = 1'b1;
      #1;
      if (req_read || req_write) begin pend_r = 1'b1; pend_id = req_id; end
      chk("ready_onehot", 64'($onehot0(p_ready)), 64'h1);
      if (p_rsp_valid != '0) begin
        outst--;
        if (gi >= 0) chk("rr_rsp_route", 64'(p_rsp_valid), 64'(1) << gi);
      end
      if (p_ready != '0) begin
        outst++;
        for (int k = 0; k < NP; k++) if (p_ready[k]) gi = k;
        grants.push_back(gi);
      end
      chk("outstanding", 64'(outst >= 0 && outst <= 1), 64'h1);
    end
    mem_ready = 1'b0; rsp_read = 1'b0;
    chk("rr_grant_count", 64'(grants.size()), 64'd14);
    foreach (grants[k]) chk("rr_order", 64'(grants[k]), 64'(k % NP));

    @(negedge clk);
    #1;
    chk("final_quiet", 64'({p_rsp_valid, req_read, req_write}), 64'h0);
    chk("final_flags", 64'({id_err, timeout_err}), 64'({exp_ide, exp_to}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
